// File: rtl/l23_buffer_pkg.sv
// Shared types and widths for the L2/L3 frame buffer read side.
package l23_buffer_pkg;

    localparam int CHAR_W = 11;
    localparam int LINE_W = 2;
    localparam int DATA_W = 8;

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } rd_state_e;

    typedef struct packed {
        logic              last;
        logic [DATA_W-1:0] data;
    } skid_entry_t;

endpackage

// File: rtl/l23_skid2.sv
// Two-entry output FIFO holding RAM read data and its last flag.
module l23_skid2
    import l23_buffer_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        push,
    input  skid_entry_t push_entry,
    input  logic        pop,
    output logic [1:0]  count,
    output skid_entry_t head
);

    skid_entry_t mem [2];
    logic        wr_ptr;
    logic        rd_ptr;

    // Push and pop on a full FIFO in the same cycle is legal: the slot
    // being overwritten is the head leaving on that same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_entry;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/l23_rd_ctrl.sv
// Read-side controller of the L2/L3 frame buffer: RAM reads to AXI-Stream.
// Optional L23_RD_FRAME_CNT_EN adds a 16-bit frame_cnt output.
//
// state  | meaning
// IDLE   | no line open, char pointer is 0
// STREAM | line open, bytes still to issue
module l23_rd_ctrl
    import l23_buffer_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int CHAR_W = 11
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rd_greenflag,
    input  logic              tlast_flag,
    input  logic [CHAR_W-1:0] rd_char_ptr,
    output logic              rd_char_incr,
    output logic              rd_char_setzero,
    output logic              rd_line_incr,
    output logic              ram_re,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic [DATA_W-1:0] m_tdata,
    output logic              m_tvalid,
    output logic              m_tlast,
    input  logic              m_tready
`ifdef L23_RD_FRAME_CNT_EN
    ,
    output logic [15:0]       frame_cnt
`endif
);

    rd_state_e   state;
    rd_state_e   state_nxt;
    logic        inflight;
    logic        inflight_last;
    logic [1:0]  skid_count;
    skid_entry_t skid_head;
    logic        pop;
    logic        credit;
    logic        last_byte;
    logic        issue;

    assign pop = m_tvalid & m_tready;

    // skid + in-flight + 1 - pop <= 2, rearranged to avoid negatives
    assign credit    = ({1'b0, skid_count} + {2'b00, inflight}) <= (3'd1 + {2'b00, pop});
    assign last_byte = tlast_flag | (rd_char_ptr == {CHAR_W{1'b1}});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (rd_greenflag && credit && !last_byte) state_nxt = STREAM;
            STREAM:  if (credit && last_byte) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        issue = 1'b0;
        case (state)
            IDLE:    issue = rd_greenflag & credit;
            STREAM:  issue = credit;
            default: issue = 1'b0;
        endcase
        ram_re          = issue;
        rd_char_incr    = issue & ~last_byte;
        rd_char_setzero = issue & last_byte;
        rd_line_incr    = issue & last_byte;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
        end else begin
            inflight      <= issue;
            inflight_last <= issue & last_byte;
        end
    end

    l23_skid2 u_skid (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (inflight),
        .push_entry ('{last: inflight_last, data: ram_rdata}),
        .pop        (pop),
        .count      (skid_count),
        .head       (skid_head)
    );

    assign m_tvalid = (skid_count != 2'd0);
    assign m_tdata  = m_tvalid ? skid_head.data : '0;
    assign m_tlast  = m_tvalid & skid_head.last;

`ifdef L23_RD_FRAME_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt <= 16'd0;
        end else if (pop && m_tlast) begin
            frame_cnt <= frame_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_l23_rd_ctrl.sv
// Bench for l23_rd_ctrl: pointer block and RAM modelled here, stream scoreboarded.
module tb_l23_rd_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rd_greenflag;
    logic        tlast_flag;
    logic [10:0] rd_char_ptr;
    logic        rd_char_incr;
    logic        rd_char_setzero;
    logic        rd_line_incr;
    logic        ram_re;
    logic [7:0]  ram_rdata;
    logic [7:0]  m_tdata;
    logic        m_tvalid;
    logic        m_tlast;
    logic        m_tready;
`ifdef L23_RD_FRAME_CNT_EN
    logic [15:0] frame_cnt;
`endif

    l23_rd_ctrl dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .rd_greenflag    (rd_greenflag),
        .tlast_flag      (tlast_flag),
        .rd_char_ptr     (rd_char_ptr),
        .rd_char_incr    (rd_char_incr),
        .rd_char_setzero (rd_char_setzero),
        .rd_line_incr    (rd_line_incr),
        .ram_re          (ram_re),
        .ram_rdata       (ram_rdata),
        .m_tdata         (m_tdata),
        .m_tvalid        (m_tvalid),
        .m_tlast         (m_tlast),
        .m_tready        (m_tready)
`ifdef L23_RD_FRAME_CNT_EN
        ,
        .frame_cnt       (frame_cnt)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // lines waiting in the buffer: length and whether a tlast index was stored
    int         lens[$];
    bit         tls[$];
    int         ptr = 0;
    int         line_serial = 0;
    // bytes issued but not yet popped, with the cycle they were issued
    logic [8:0] exp_q[$];
    int         iss_cyc[$];
    int         fcnt = 0;
    int         mode = 0;
    int         pat_i = 0;
    logic       s_re = 0, s_incr = 0, s_zero = 0, s_line = 0;
    int         n_incr = 0, n_line = 0, n_re = 0;
    int         exp_incr = 0, exp_lines = 0;
    int         line_cyc[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [7:0] byte_of(input int s, input int p);
        return 8'((s * 53 + p * 7 + 1) & 255);
    endfunction

    task automatic add_line(input int len, input bit has_tl);
        lens.push_back(len);
        tls.push_back(has_tl);
        exp_incr  += len - 1;
        exp_lines += 1;
    endtask

    task automatic step();
        logic vexp, pop_m, re_exp, last_exp;
        @(posedge clk);
        #1;
        cyc++;
        // pointer block and RAM react to what the DUT asked for last cycle
        if (s_re) begin
            ram_rdata = byte_of(line_serial, ptr);
            if (s_zero) ptr = 0;
            else if (s_incr) ptr = (ptr + 1) & 2047;
        end else begin
            ram_rdata = 8'($urandom);
        end
        if (s_line && lens.size() > 0) begin
            void'(lens.pop_front());
            void'(tls.pop_front());
            line_serial++;
        end
        rd_greenflag = (lens.size() > 0);
        rd_char_ptr  = 11'(ptr);
        tlast_flag   = (lens.size() > 0) && tls[0] && (ptr == lens[0] - 1);
        case (mode)
            0:       m_tready = 1'b1;
            1:       m_tready = (pat_i % 4 == 0) || (pat_i % 4 == 3);
            2:       m_tready = 1'($urandom_range(0, 1));
            default: m_tready = 1'b0;
        endcase
        pat_i++;
        @(negedge clk);
        vexp  = (iss_cyc.size() > 0) && (iss_cyc[0] <= cyc - 2);
        pop_m = vexp && m_tready;
        check("tvalid", 32'(m_tvalid), 32'(vexp));
        if (vexp) begin
            check("tdata", 32'(m_tdata), 32'(exp_q[0][7:0]));
            check("tlast", 32'(m_tlast), 32'(exp_q[0][8]));
        end
        re_exp   = (lens.size() > 0) && (exp_q.size() - int'(pop_m) <= 1);
        last_exp = (lens.size() > 0) && ((ptr == lens[0] - 1) || (ptr == 2047));
        check("ram_re", 32'(ram_re), 32'(re_exp));
        check("char_incr", 32'(rd_char_incr), 32'(re_exp && !last_exp));
        check("char_setzero", 32'(rd_char_setzero), 32'(re_exp && last_exp));
        check("line_incr", 32'(rd_line_incr), 32'(re_exp && last_exp));
        if (pop_m) begin
            if (exp_q[0][8]) fcnt++;
            void'(exp_q.pop_front());
            void'(iss_cyc.pop_front());
        end
        if (re_exp) begin
            exp_q.push_back({last_exp, byte_of(line_serial, ptr)});
            iss_cyc.push_back(cyc);
        end
        n_incr += int'(rd_char_incr);
        n_line += int'(rd_line_incr);
        n_re   += int'(ram_re);
        if (rd_line_incr) line_cyc.push_back(cyc);
        s_re   = ram_re;
        s_incr = rd_char_incr;
        s_zero = rd_char_setzero;
        s_line = rd_line_incr;
    endtask

    task automatic check_fcnt();
`ifdef L23_RD_FRAME_CNT_EN
        check("frame_cnt", 32'(frame_cnt), 32'(fcnt & 16'hFFFF));
`endif
    endtask

    task automatic run(input string tag, input int budget);
        int n = 0;
        while ((lens.size() > 0 || exp_q.size() > 0) && n < budget) begin
            step();
            n++;
        end
        check({tag, "_drain"}, 32'(lens.size() + exp_q.size()), 32'd0);
        check({tag, "_incr_cnt"}, 32'(n_incr), 32'(exp_incr));
        check({tag, "_line_cnt"}, 32'(n_line), 32'(exp_lines));
        check_fcnt();
        n_incr = 0; n_line = 0; n_re = 0; exp_incr = 0; exp_lines = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n        = 1'b0;
        rd_greenflag = 1'b0;
        tlast_flag   = 1'b0;
        rd_char_ptr  = '0;
        m_tready     = 1'b0;
        ram_rdata    = '0;
        #1;
        check("rst_tvalid", 32'(m_tvalid), 32'd0);
        check("rst_tlast", 32'(m_tlast), 32'd0);
        check("rst_tdata", 32'(m_tdata), 32'd0);
        check("rst_ram_re", 32'(ram_re), 32'd0);
        check("rst_incr", 32'(rd_char_incr), 32'd0);
        check("rst_setzero", 32'(rd_char_setzero), 32'd0);
        check("rst_line_incr", 32'(rd_line_incr), 32'd0);
        lens.delete(); tls.delete(); exp_q.delete(); iss_cyc.delete();
        ptr = 0; fcnt = 0;
        s_re = 0; s_incr = 0; s_zero = 0; s_line = 0;
        n_incr = 0; n_line = 0; n_re = 0; exp_incr = 0; exp_lines = 0;
        check_fcnt();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n        = 1'b0;
        rd_greenflag = 1'b0;
        tlast_flag   = 1'b0;
        rd_char_ptr  = '0;
        m_tready     = 1'b0;
        ram_rdata    = '0;
        do_reset();

        mode = 0; add_line(1, 1);
        run("one_byte", 20);

        mode = 0; add_line(64, 1);
        run("len64", 200);

        mode = 1; pat_i = 0; add_line(64, 1);
        run("len64_stall", 400);

        mode = 0; line_cyc.delete(); add_line(3, 1); add_line(5, 1);
        run("b2b", 40);
        if (line_cyc.size() == 2) check("b2b_line_gap", 32'(line_cyc[1] - line_cyc[0]), 32'd5);
        else check("b2b_line_pulses", 32'(line_cyc.size()), 32'd2);

        mode = 0; add_line(2048, 0);
        run("guard", 2200);

        mode = 2;
        for (int i = 0; i < 8; i++) add_line(int'($urandom_range(1, 40)), 1'b1);
        run("rand", 1500);

        mode = 3; add_line(100, 1);
        for (int i = 0; i < 8; i++) step();
        check("stall_issues", 32'(n_re), 32'd2);
        do_reset();

        mode = 0; add_line(4, 1); add_line(7, 1);
        run("post_rst", 60);

        mode = 2;
        for (int i = 0; i < 10; i++) add_line(int'($urandom_range(1, 24)), 1'b1);
        run("rand2", 1500);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
